// File: rtl/scroll_pattern_gen.sv
// ---------------------------------------------------------------------------
// scroll_pattern_gen
//
// Video test-pattern source. Generates raster timing (negative-polarity
// HSYNC/VSYNC plus an active-video qualifier) and fills the active window
// with black, a one-pixel checkerboard, a static LFSR noise field, or a
// noise field that scrolls upward by a programmable number of lines per
// frame. All outputs except PCLK_out are registered one cycle behind the
// raster counters.
//
// Ports
//   clk27        : pixel clock, every register updates on its rising edge
//   reset        : synchronous, active-high
//   mode         : 0 black, 1 checkerboard, 2 static noise, 3 scrolling noise
//   scroll_speed : LFSR steps added to the frame seed per frame (mode 3)
//   R_out/G_out/B_out : pixel data (all three identical), zero when blanked
//   HSYNC_out    : horizontal sync, low during the sync pulse
//   VSYNC_out    : vertical sync, low during the sync pulse
//   ENABLE_out   : high during active video
//   PCLK_out     : copy of clk27
//   frame_start  : one-cycle pulse following raster position (0,0)
// ---------------------------------------------------------------------------
module scroll_pattern_gen #(
    parameter int H_SYNCLEN   = 62,
    parameter int H_BACKPORCH = 60,
    parameter int H_ACTIVE    = 720,
    parameter int H_TOTAL     = 858,
    parameter int V_SYNCLEN   = 6,
    parameter int V_BACKPORCH = 30,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int DATA_W      = 8,
    parameter int LFSR_W      = 8,
    parameter int TAP_A       = 7,
    parameter int TAP_B       = 3,
    parameter logic [LFSR_W-1:0] SEED     = '0,
    parameter logic [DATA_W-1:0] NOISE_HI = DATA_W'('hdf),
    parameter logic [DATA_W-1:0] NOISE_LO = DATA_W'('h20)
) (
    input  logic              clk27,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [3:0]        scroll_speed,
    output logic [DATA_W-1:0] R_out,
    output logic [DATA_W-1:0] G_out,
    output logic [DATA_W-1:0] B_out,
    output logic              HSYNC_out,
    output logic              VSYNC_out,
    output logic              ENABLE_out,
    output logic              PCLK_out,
    output logic              frame_start
);

    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int X_START = H_SYNCLEN + H_BACKPORCH;
    localparam int Y_START = V_SYNCLEN + V_BACKPORCH;
    localparam int X_END   = X_START + H_ACTIVE;
    localparam int Y_END   = Y_START + V_ACTIVE;

    logic [H_W-1:0]    h_cnt;
    logic [V_W-1:0]    v_cnt;
    logic [1:0]        mode_lat;
    logic [3:0]        step_cnt;
    logic [LFSR_W-1:0] frame_seed;
    logic [LFSR_W-1:0] line_seed;
    logic [LFSR_W-1:0] pix_lfsr;

    logic              at_origin;
    logic              h_end;
    logic              v_act;
    logic              in_active;
    logic              line_load;
    logic [DATA_W-1:0] pix_val;

    // XNOR Fibonacci step: the all-ones state is the lock-up state, so the
    // all-zero seed is a legal starting point.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ~(s[TAP_A] ^ s[TAP_B])};
    endfunction

    assign PCLK_out  = clk27;
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    assign h_end     = (int'(h_cnt) == H_TOTAL - 1);
    assign v_act     = (int'(v_cnt) >= Y_START) && (int'(v_cnt) < Y_END);
    assign in_active = v_act && (int'(h_cnt) >= X_START) && (int'(h_cnt) < X_END);
    // One cycle before the first active pixel of an active line, the pixel
    // generator is reloaded from the line seed.
    assign line_load = v_act && (int'(h_cnt) == X_START - 1);

    // Raster counters. Reset parks them at the origin, so the first cycle
    // after release is treated exactly like the start of a new frame.
    always_ff @(posedge clk27) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_end) begin
            h_cnt <= '0;
            if (int'(v_cnt) == V_TOTAL - 1)
                v_cnt <= '0;
            else
                v_cnt <= v_cnt + V_W'(1);
        end else begin
            h_cnt <= h_cnt + H_W'(1);
        end
    end

    // Mode/speed latching and the three-level LFSR chain. The frame seed
    // advances by the latched step count during the top blanking lines, the
    // line seed snapshots it just before the first active line and then
    // advances once per line, and the pixel LFSR runs across each line.
    // Line seeds advancing by one step per line is what makes a per-frame
    // seed advance show up as a vertical scroll.
    always_ff @(posedge clk27) begin
        if (reset) begin
            mode_lat   <= 2'd0;
            step_cnt   <= 4'd0;
            frame_seed <= SEED;
            line_seed  <= SEED;
            pix_lfsr   <= SEED;
        end else begin
            if (at_origin) begin
                mode_lat <= mode;
                step_cnt <= (mode == 2'd2) ? 4'd0 : scroll_speed;
            end else if ((step_cnt != 4'd0) && (int'(v_cnt) < Y_START)) begin
                frame_seed <= lfsr_step(frame_seed);
                step_cnt   <= step_cnt - 4'd1;
            end

            if ((h_cnt == '0) && (int'(v_cnt) == Y_START - 1))
                line_seed <= frame_seed;
            else if (line_load)
                line_seed <= lfsr_step(line_seed);

            if (line_load)
                pix_lfsr <= line_seed;
            else if (in_active)
                pix_lfsr <= lfsr_step(pix_lfsr);
        end
    end

    // Pixel value for the current raster position under the latched mode.
    always_comb begin
        pix_val = '0;
        case (mode_lat)
            2'd1:    pix_val = (h_cnt[0] ^ v_cnt[0]) ? '1 : '0;
            2'd2,
            2'd3:    pix_val = pix_lfsr[LFSR_W-1] ? NOISE_LO : NOISE_HI;
            default: pix_val = '0;
        endcase
    end

    // Registered video outputs, one cycle behind the counters. Colour is
    // forced to zero whenever the qualifier is low.
    always_ff @(posedge clk27) begin
        if (reset) begin
            HSYNC_out   <= 1'b0;
            VSYNC_out   <= 1'b0;
            ENABLE_out  <= 1'b0;
            frame_start <= 1'b0;
            R_out       <= '0;
            G_out       <= '0;
            B_out       <= '0;
        end else begin
            HSYNC_out   <= (int'(h_cnt) >= H_SYNCLEN);
            VSYNC_out   <= (int'(v_cnt) >= V_SYNCLEN);
            ENABLE_out  <= in_active;
            frame_start <= at_origin;
            R_out       <= in_active ? pix_val : '0;
            G_out       <= in_active ? pix_val : '0;
            B_out       <= in_active ? pix_val : '0;
        end
    end

endmodule

// File: tb/tb_scroll_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_scroll_pattern_gen
//
// Bench for scroll_pattern_gen using a shrunken raster (28 x 30 pixels,
// 16 x 20 active) so many frames fit in a short run. A position-based
// reference model predicts every output on every cycle: noise pixels are
// looked up in a precomputed LFSR sequence indexed by
// frame offset + line + pixel. A table of hand-derived probe points and a
// few directed sequences cover the frame-level properties.
// ---------------------------------------------------------------------------
module tb_scroll_pattern_gen;

    localparam int H_SYNC  = 4;
    localparam int H_BP    = 3;
    localparam int H_ACT   = 16;
    localparam int H_TOT   = 28;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 3;
    localparam int V_ACT   = 20;
    localparam int V_TOT   = 30;
    localparam int X_START = H_SYNC + H_BP;
    localparam int Y_START = V_SYNC + V_BP;
    localparam int FRAME   = H_TOT * V_TOT;

    typedef struct {
        int         h;
        int         v;
        logic [7:0] px;
        logic       hs;
        logic       vs;
        logic       en;
        logic       fs;
    } vec_t;

    logic       clk27 = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic [3:0] scroll_speed;
    logic [7:0] R_out, G_out, B_out;
    logic       HSYNC_out, VSYNC_out, ENABLE_out, PCLK_out, frame_start;

    int check_count = 0;
    int pass_count  = 0;

    // Reference model state
    int         mh, mv;
    int         lat_mode;
    int         offset;
    logic [7:0] seq [2048];
    logic [7:0] img [2][V_ACT][H_ACT];
    int         cap_slot = -1;
    int         hs_low, vs_low, en_high, fs_cnt;

    vec_t tbl [13];

    scroll_pattern_gen #(
        .H_SYNCLEN(H_SYNC), .H_BACKPORCH(H_BP), .H_ACTIVE(H_ACT), .H_TOTAL(H_TOT),
        .V_SYNCLEN(V_SYNC), .V_BACKPORCH(V_BP), .V_ACTIVE(V_ACT), .V_TOTAL(V_TOT),
        .DATA_W(8), .LFSR_W(8), .TAP_A(7), .TAP_B(3), .SEED(8'h00),
        .NOISE_HI(8'hdf), .NOISE_LO(8'h20)
    ) dut (
        .clk27(clk27), .reset(reset), .mode(mode), .scroll_speed(scroll_speed),
        .R_out(R_out), .G_out(G_out), .B_out(B_out),
        .HSYNC_out(HSYNC_out), .VSYNC_out(VSYNC_out), .ENABLE_out(ENABLE_out),
        .PCLK_out(PCLK_out), .frame_start(frame_start)
    );

    always #5 clk27 = ~clk27;

    function automatic logic [7:0] noise_px(input int k);
        return seq[k % 2048][7] ? 8'h20 : 8'hdf;
    endfunction

    task automatic applyStimulus(input logic [1:0] m, input logic [3:0] s);
        mode         = m;
        scroll_speed = s;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got %h expected %h (model h=%0d v=%0d)",
                     name, actual, expected, mh, mv);
    endtask

    // One clock: predict outputs from the model position, compare after the
    // edge, then advance the model.
    task automatic tick();
        logic [7:0] e_px;
        logic       e_hs, e_vs, e_en, e_fs, act;
        act  = (mh >= X_START) && (mh < X_START + H_ACT) &&
               (mv >= Y_START) && (mv < Y_START + V_ACT);
        e_px = 8'h00;
        e_hs = 1'b0; e_vs = 1'b0; e_en = 1'b0; e_fs = 1'b0;
        if (!reset) begin
            e_hs = (mh >= H_SYNC);
            e_vs = (mv >= V_SYNC);
            e_en = act;
            e_fs = (mh == 0) && (mv == 0);
            if (act) begin
                case (lat_mode)
                    1:       e_px = (((mh ^ mv) & 1) != 0) ? 8'hff : 8'h00;
                    2, 3:    e_px = noise_px(offset + (mv - Y_START) + (mh - X_START));
                    default: e_px = 8'h00;
                endcase
            end
        end
        @(posedge clk27);
        #1;
        checkOutput("cycle",
                    {3'b000, R_out, G_out, B_out, HSYNC_out, VSYNC_out, ENABLE_out, frame_start, PCLK_out},
                    {3'b000, e_px, e_px, e_px, e_hs, e_vs, e_en, e_fs, 1'b1});
        if (!HSYNC_out) hs_low++;
        if (!VSYNC_out) vs_low++;
        if (ENABLE_out) en_high++;
        if (frame_start) fs_cnt++;
        if (!reset && act && cap_slot >= 0)
            img[cap_slot][mv - Y_START][mh - X_START] = R_out;
        if (reset) begin
            mh = 0; mv = 0; lat_mode = 0; offset = 0;
        end else begin
            if (mh == 0 && mv == 0) begin
                lat_mode = int'(mode);
                offset   = offset + ((mode == 2'd2) ? 0 : int'(scroll_speed));
            end
            mh++;
            if (mh == H_TOT) begin
                mh = 0;
                mv = (mv == V_TOT - 1) ? 0 : mv + 1;
            end
        end
    endtask

    // Advance until the model position equals (h,v), then clock it so the
    // outputs on return belong to that position.
    task automatic run_to(input int h, input int v);
        int budget = FRAME + 2;
        while (!(mh == h && mv == v) && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0)
            checkOutput("run_to_timeout", 32'(budget), 32'(1));
        tick();
    endtask

    // Run one whole frame from the origin, capturing active pixels into the
    // given slot and counting sync/enable cycles.
    task automatic run_frame(input int slot);
        int budget = FRAME + 2;
        while (!(mh == 0 && mv == 0) && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0)
            checkOutput("frame_align_timeout", 32'(budget), 32'(1));
        hs_low = 0; vs_low = 0; en_high = 0; fs_cnt = 0;
        cap_slot = slot;
        repeat (FRAME) tick();
        cap_slot = -1;
    endtask

    function automatic int frame_diff(input int shift);
        int d = 0;
        for (int n = 0; n < V_ACT - shift; n++)
            for (int p = 0; p < H_ACT; p++)
                if (img[1][n][p] !== img[0][n + shift][p]) d++;
        return d;
    endfunction

    initial begin
        logic [7:0] s;
        logic       nb;
        s = 8'h00;
        for (int k = 0; k < 2048; k++) begin
            seq[k] = s;
            nb = ~(s[7] ^ s[3]);
            s  = ((s << 1) & 8'hfe) | {7'b0, nb};
        end

        // Probe points for a mode-1 frame: position, pixel, hs, vs, en, fs.
        tbl[0]  = '{0,  0,  8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{3,  0,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{4,  0,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{10, 1,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{10, 2,  8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{6,  5,  8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{7,  5,  8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{8,  5,  8'hff, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{22, 5,  8'hff, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{23, 5,  8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{7,  24, 8'hff, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{7,  25, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{27, 29, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};

        mh = 0; mv = 0; lat_mode = 0; offset = 0;
        reset = 1'b1;
        applyStimulus(2'd1, 4'd0);
        repeat (3) tick();
        reset = 1'b0;

        $display("[TB] checkerboard probe table");
        for (int i = 0; i < 13; i++) begin
            run_to(tbl[i].h, tbl[i].v);
            checkOutput("table", {19'b0, R_out, HSYNC_out, VSYNC_out, ENABLE_out, frame_start},
                        {19'b0, tbl[i].px, tbl[i].hs, tbl[i].vs, tbl[i].en, tbl[i].fs});
        end

        $display("[TB] frame timing counts");
        run_frame(0);
        checkOutput("hsync_low_cycles", 32'(hs_low), 32'(H_SYNC * V_TOT));
        checkOutput("vsync_low_cycles", 32'(vs_low), 32'(V_SYNC * H_TOT));
        checkOutput("enable_cycles", 32'(en_high), 32'(H_ACT * V_ACT));
        checkOutput("frame_start_count", 32'(fs_cnt), 32'(1));

        $display("[TB] static noise");
        applyStimulus(2'd2, 4'd5);
        run_frame(0);
        run_frame(1);
        checkOutput("m2_frames_identical", 32'(frame_diff(0)), 32'(0));
        checkOutput("m2_first_px", 32'(img[0][0][0]), 32'h000000df);
        checkOutput("m2_line1_px0_eq_line0_px1", 32'(img[0][1][0]), 32'(img[0][0][1]));

        $display("[TB] scrolling noise");
        applyStimulus(2'd3, 4'd0);
        run_frame(0);
        run_frame(1);
        checkOutput("m3_speed0_identical", 32'(frame_diff(0)), 32'(0));
        applyStimulus(2'd3, 4'd1);
        run_frame(0);
        run_frame(1);
        checkOutput("m3_speed1_shift", 32'(frame_diff(1)), 32'(0));
        checkOutput("m3_speed1_not_static", 32'(frame_diff(0) != 0), 32'(1));
        applyStimulus(2'd3, 4'd15);
        run_frame(0);
        run_frame(1);
        checkOutput("m3_speed15_shift", 32'(frame_diff(15)), 32'(0));

        $display("[TB] mid-frame mode switch");
        applyStimulus(2'd1, 4'd0);
        run_frame(-1);
        run_to(0, 12);
        applyStimulus(2'd2, 4'd0);
        run_to(8, 15);
        checkOutput("switch_still_checker", 32'(R_out), 32'h000000ff);
        run_to(X_START, Y_START);
        checkOutput("switch_noise_next_frame", 32'(R_out), 32'(noise_px(offset)));

        $display("[TB] mid-frame reset");
        run_to(0, 18);
        reset = 1'b1;
        tick();
        checkOutput("reset_outputs_zero",
                    {3'b000, R_out, G_out, B_out, HSYNC_out, VSYNC_out, ENABLE_out, frame_start, 1'b0},
                    32'h0);
        reset = 1'b0;
        tick();
        checkOutput("frame_start_after_reset", 32'(frame_start), 32'(1));
        run_to(X_START, Y_START);
        checkOutput("reset_noise_restart", 32'(R_out), 32'h000000df);

        $display("[TB] randomized run");
        for (int c = 0; c < 8 * FRAME; c++) begin
            if ($urandom_range(63) == 0)
                applyStimulus(2'($urandom_range(3)), 4'($urandom_range(15)));
            reset = ($urandom_range(2999) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
